// File: rtl/alu_sel_pkg.sv
// ============================================================================
// alu_sel_pkg : shared types, defaults and opcode constants for the ALU
//               select sequencer.  Rev 1.0
// ============================================================================
`default_nettype none

package alu_sel_pkg;

    localparam int ALU_OPW  = 4;
    localparam int ALU_NSEL = 2 ** ALU_OPW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam logic [ALU_OPW-1:0] OP_ADD = 4'd0;
    localparam logic [ALU_OPW-1:0] OP_SUB = 4'd1;
    localparam logic [ALU_OPW-1:0] OP_AND = 4'd2;
    localparam logic [ALU_OPW-1:0] OP_OR  = 4'd3;
    localparam logic [ALU_OPW-1:0] OP_SHL = 4'd8;
    localparam logic [ALU_OPW-1:0] OP_MUL = 4'd12;

    function automatic logic [ALU_NSEL-1:0] onehot(input logic [ALU_OPW-1:0] op);
        return ALU_NSEL'(1) << op;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_sel_fifo.sv
// ============================================================================
// alu_sel_fifo : synchronous FIFO with combinational head read and
//                wrap-bit pointers.  Rev 1.0
// ============================================================================
`default_nettype none

module alu_sel_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rptr_q[AW-1:0]];

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_sel_sequencer.sv
// ============================================================================
// alu_sel_sequencer : buffers ALU opcodes and presents a registered one-hot
//                     select, held until acknowledged.  Rev 1.0
// Optional: ALU_SEL_BYPASS_EN lets a push into an empty, ready block skip the FIFO.
// ============================================================================
`default_nettype none

module alu_sel_sequencer
    import alu_sel_pkg::*;
#(
    parameter int              OPW       = ALU_OPW,
    parameter int              NSEL      = 2 ** OPW,
    parameter int              DEPTH     = 4,
    parameter logic [NSEL-1:0] MC_MASK   = '0,
    parameter int              MC_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  in_op,
    output logic [NSEL-1:0] out_sel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy
);

    localparam int CW = $clog2(MC_CYCLES + 1);

    logic            fifo_empty;
    logic            fifo_full;
    logic [OPW-1:0]  fifo_dout;
    logic            take;
    logic            bypass;
    logic            pop;
    logic            push;
    logic            load;
    logic [OPW-1:0]  load_op;

    state_e          state_q;
    logic [NSEL-1:0] sel_q;
    logic            valid_q;
    logic [CW-1:0]   cnt_q;

    // The FSM can take a new op when idle, or when the held result is being accepted.
    assign take = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);

`ifdef ALU_SEL_BYPASS_EN
    assign bypass = take && fifo_empty && in_valid;
`else
    assign bypass = 1'b0;
`endif

    assign pop      = take && !fifo_empty;
    assign load     = pop || bypass;
    assign load_op  = bypass ? in_op : fifo_dout;
    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready && !bypass;
    assign busy     = !fifo_empty || (state_q != ST_IDLE);

    assign out_sel   = sel_q;
    assign out_valid = valid_q;

    alu_sel_fifo #(
        .WIDTH (OPW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (in_op),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_EXEC: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_HOLD;
                        valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    if (load) begin
                        sel_q <= NSEL'(1) << load_op;
                        cnt_q <= CW'(MC_CYCLES - 1);
                        if (MC_MASK[load_op]) begin
                            state_q <= ST_EXEC;
                            valid_q <= 1'b0;
                        end else begin
                            state_q <= ST_HOLD;
                            valid_q <= 1'b1;
                        end
                    end else if ((state_q == ST_HOLD) && out_ready) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        sel_q   <= '0;
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_sel_sequencer.sv
// ============================================================================
// tb_alu_sel_sequencer : scoreboard bench for alu_sel_sequencer.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_alu_sel_sequencer;

    localparam int          MCC = 4;
    localparam logic [15:0] MCM = 16'h1000;
`ifdef ALU_SEL_BYPASS_EN
    localparam int L0 = 0;
`else
    localparam int L0 = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [15:0] out_sel;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int          n_cmp;
    int          n_err;
    logic [3:0]  exp_q[$];
    logic [15:0] mcm_v;

    alu_sel_sequencer #(
        .OPW       (4),
        .NSEL      (16),
        .DEPTH     (4),
        .MC_MASK   (MCM),
        .MC_CYCLES (MCC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: accepted ops are queued; each result handshake pops one.
    initial begin : monitor
        int   lowcnt;
        bit   checked;
        logic [3:0] op;
        lowcnt  = 0;
        checked = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                lowcnt  = 0;
                checked = 1'b0;
            end else begin
                if (out_valid && !checked && exp_q.size() > 0) begin
                    op = exp_q[0];
                    chk("exec_len", 32'(lowcnt), mcm_v[op] ? 32'(MCC) : 32'd0);
                    checked = 1'b1;
                end
                if (!out_valid && out_sel != 16'h0) begin
                    lowcnt++;
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("stray_output", 32'(out_sel), 32'd0);
                    end else begin
                        op = exp_q.pop_front();
                        chk("sb_sel", 32'(out_sel), 32'(16'h1 << op));
                    end
                    lowcnt  = 0;
                    checked = 1'b0;
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back(in_op);
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic push_op(input logic [3:0] op);
        int t;
        in_valid = 1'b1;
        in_op    = op;
        t        = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 1000);
        if (!in_ready) chk("push_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
        $fatal(1);
    end

    initial begin : stim
        int t;
        n_cmp     = 0;
        n_err     = 0;
        mcm_v     = MCM;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 4'h0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sel", 32'(out_sel), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        #1 rst_n = 1'b1;
        step();

        // Single-cycle op
        out_ready = 1'b1;
        push_op(4'd3);
        if (L0 == 1) begin
            chk("single_pre", 32'(out_valid), 32'd0);
            step();
        end
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_sel", 32'(out_sel), 32'h0008);
        step();
        chk("single_after_valid", 32'(out_valid), 32'd0);
        chk("single_after_sel", 32'(out_sel), 32'd0);
        step();

        // Multi-cycle op
        push_op(4'd12);
        if (L0 == 1) step();
        for (int k = 0; k < MCC; k++) begin
            chk("mc_sel_exec", 32'(out_sel), 32'h1000);
            chk("mc_valid_low", 32'(out_valid), 32'd0);
            step();
        end
        chk("mc_valid_high", 32'(out_valid), 32'd1);
        chk("mc_sel_hold", 32'(out_sel), 32'h1000);
        step();
        chk("mc_done", 32'(out_valid), 32'd0);
        step();

        // Backpressure, full, and full-plus-pop refusal
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) push_op(4'(k));
        in_valid = 1'b1;
        in_op    = 4'd5;
        @(negedge clk);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("bp_hold_sel", 32'(out_sel), 32'h0001);
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        step();
        out_ready = 1'b1;
        @(negedge clk);
        chk("full_pop_refuse", 32'(in_ready), 32'd0);
        step();
        chk("b2b_sel1", 32'(out_sel), 32'h0002);
        @(negedge clk);
        chk("refill_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("b2b_sel2", 32'(out_sel), 32'h0004);
        for (int k = 3; k <= 5; k++) begin
            step();
            chk("b2b_sel", 32'(out_sel), 32'(16'h1 << k));
            chk("b2b_valid", 32'(out_valid), 32'd1);
        end
        step();
        chk("b2b_end_valid", 32'(out_valid), 32'd0);
        chk("b2b_end_busy", 32'(busy), 32'd0);

`ifdef ALU_SEL_BYPASS_EN
        push_op(4'd2);
        chk("byp_sel", 32'(out_sel), 32'h0004);
        chk("byp_valid", 32'(out_valid), 32'd1);
        step();
        chk("byp_empty", 32'(busy), 32'd0);
`endif

        // Reset mid-operation with ops queued
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) push_op(4'(k));
        rst_n = 1'b0;
        #1;
        chk("mrst_sel", 32'(out_sel), 32'd0);
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        step();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("mrst_no_stale", 32'(out_valid), 32'd0);
        end
        chk("mrst_idle_busy", 32'(busy), 32'd0);

        // Randomised traffic
        for (int c = 0; c < 500; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_op     = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        t = 0;
        while ((busy || out_valid) && t < 500) begin
            step();
            t++;
        end
        chk("drain_timeout", 32'(busy || out_valid), 32'd0);
        step();
        chk("drain_queue", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_sel_sequencer.md
Name: alu_sel_sequencer

Overview:
- Upstream control stage for the ALU result multiplexers (16-way priority-select mux).
- Accepts 4-bit ALU opcodes over a valid/ready handshake and buffers them in a small FIFO.
- Converts each opcode to a registered one-hot select vector and holds it stable, for a configurable number of cycles on multi-cycle ops, until the consumer acknowledges it.

Parameters:
- OPW, 4, opcode width; NSEL = 2**OPW.
- NSEL, 16, select vector width; must equal 2**OPW.
- DEPTH, 4, opcode FIFO depth; power of two, at least 2.
- MC_MASK, 16'h0000, bit i set means opcode i is multi-cycle.
- MC_CYCLES, 4, execute cycles for a multi-cycle op; at least 1.

Ports:
- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  opcode offered
- in_ready  output  1  FIFO can accept
- in_op  input  OPW  opcode
- out_sel  output  NSEL  one-hot select to the result mux; bit i means opcode i
- out_valid  output  1  out_sel holds a completed op
- out_ready  input  1  consumer accepts result
- busy  output  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Ports are clk and rst_n.
- Reset values: out_sel=0, out_valid=0, busy=0, in_ready=1. FIFO is emptied, counter=0, state=IDLE.
- Reset mid-operation discards all queued and in-flight ops immediately.
- out_sel=0 makes the downstream mux default to its last input. Consumers qualify out_sel with out_valid only.
- Push: occurs when in_valid and in_ready are both high. in_ready = !full, registered-state based.
- When full, in_ready stays low even if a pop occurs in the same cycle. No same-cycle refill when full.
- Pop: performed only by the FSM. FIFO read data is combinational from the head.
- FSM states: IDLE, EXEC, HOLD.
  - IDLE to EXEC: FIFO non-empty and head op is in MC_MASK. Pop; out_sel <= onehot(op); counter <= MC_CYCLES-1; out_valid stays 0.
  - IDLE to HOLD: FIFO non-empty and head op is not in MC_MASK. Pop; out_sel <= onehot(op); out_valid <= 1.
  - EXEC: counter decrements each cycle. When counter==0, go to HOLD and set out_valid <= 1. out_sel is stable throughout EXEC.
  - HOLD: out_sel and out_valid are held until out_ready. On the out_ready handshake:
    - FIFO non-empty: pop the next op in the same cycle and go to EXEC or HOLD per the IDLE rules (back-to-back, no bubble).
    - FIFO empty: go to IDLE with out_valid <= 0 and out_sel <= 0.
- Latency, single-cycle op into an empty FIFO: accepted at edge N, out_valid high after edge N+1.
- Latency, multi-cycle op: out_valid high after edge N+1+MC_CYCLES.
- Throughput: one op per cycle when out_ready is tied high and all ops are single-cycle.
- Out-of-range opcodes are not possible (full 2**OPW decode). onehot(op) = 1 << op.
- FIFO read and write pointers are OPW-independent, log2(DEPTH)+1 bits, and wrap naturally. full/empty come from comparing pointer MSBs.
- busy = !empty || state != IDLE.

Optional Feature:
- Macro: ALU_SEL_BYPASS_EN.
- Defined: a push that finds the FIFO empty and the FSM in IDLE (or in HOLD with out_ready high) bypasses the FIFO.
  - The FSM loads the incoming op directly in that cycle.
  - Single-cycle latency becomes out_valid high after edge N.
  - No FIFO write occurs for the bypassed op.
- Undefined: all ops pass through the FIFO, with latencies as in Behaviour.

Decomposition:
- Package alu_sel_pkg holds:
  - OPW and NSEL defaults.
  - State enum {IDLE, EXEC, HOLD}.
  - Opcode constants, e.g. OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_SHL=8, OP_MUL=12.
  - onehot function.
- Sub-module alu_sel_fifo: synchronous FIFO parameterised by width and depth, with push, pop, full, empty, and dout.

Test Plan:
- Reset then idle: rst_n low mid-run with 3 ops queued, release -> out_sel=0, out_valid=0, busy=0, in_ready=1, no stale op emitted.
- Single op: push op 3 at edge N with out_ready=1 -> out_sel=16'h0008 and out_valid=1 after edge N+1, one cycle only, then out_sel=0.
- Multi-cycle: MC_MASK=16'h1000, MC_CYCLES=4, push op 12 -> out_sel=16'h1000 after N+1, out_valid low for 4 cycles, high after N+5.
- Backpressure and full: out_ready=0, push ops 0,1,2,3,4 -> first op held in HOLD, 4 in FIFO, in_ready=0. Release out_ready -> outputs 0001, 0002, 0004, 0008, 0010 in consecutive cycles, with no bubble.
- Full plus pop same cycle: FIFO full, out_ready=1, in_valid=1 -> push refused that cycle, accepted the next.
- ALU_SEL_BYPASS_EN defined: push op 2 into an empty idle block -> out_sel=16'h0004 and out_valid=1 after edge N; FIFO stays empty.
